// File: rtl/hdmi_pkg.sv
// Shared types and constants for the HDMI data-island packet path.
package hdmi_pkg;

    localparam int PACKET_CLOCKS = 32;
    localparam int HEADER_BITS   = 24;
    localparam int SUB_BITS      = 56;
    localparam int SUBPACKETS    = 4;

    // Reflected BCH generator for x^8+x^7+x^6+1
    localparam logic [7:0] ECC_POLY_DEFAULT = 8'h83;

    typedef logic [HEADER_BITS-1:0] packet_header_t;
    typedef logic [SUB_BITS-1:0]    subpacket_t;

    typedef enum logic {
        ST_IDLE,
        ST_SEND
    } serializer_state_t;

endpackage

// File: rtl/bch_ecc_step.sv
// One clock's worth of BCH parity update, LSB-first, 1 or 2 data bits.
module bch_ecc_step
    import hdmi_pkg::*;
#(
    parameter int unsigned BITS_PER_CLK = 1,
    parameter logic [7:0]  ECC_POLY     = ECC_POLY_DEFAULT
) (
    input  logic [7:0]              ecc,
    input  logic [BITS_PER_CLK-1:0] data,
    output logic [7:0]              ecc_next
);

    // Apply data[0] first, then data[1] when two bits arrive per clock
    always_comb begin
        ecc_next = ecc;
        for (int unsigned i = 0; i < BITS_PER_CLK; i++) begin
            ecc_next = (ecc_next >> 1) ^ (((ecc_next[0] ^ data[i]) == 1'b1) ? ECC_POLY : 8'h00);
        end
    end

endmodule

// File: rtl/data_island_packet_serializer.sv
// Stages one packet, appends BCH parity and serializes it over a 32-clock slot.
module data_island_packet_serializer
    import hdmi_pkg::*;
#(
    parameter logic [7:0] ECC_POLY = ECC_POLY_DEFAULT
) (
    input  logic              clk_pixel,
    input  logic              reset_n,
    input  logic [23:0]       in_header,
    input  logic [3:0][55:0]  in_sub,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              start,
    output logic              packet_enable,
    output logic [8:0]        packet_data,
    output logic              packet_done
);

    localparam logic [4:0] LAST_CNT   = 5'(PACKET_CLOCKS - 1);
    localparam logic [4:0] HDR_CNT    = 5'(HEADER_BITS);
    localparam logic [4:0] SUB_CNT    = 5'(SUB_BITS / 2);

    serializer_state_t     state_q, state_d;
    logic [4:0]            cnt_q, cnt_d;
    logic                  staged_full_q, staged_full_d;
    packet_header_t        staged_hdr_q, staged_hdr_d;
    subpacket_t [3:0]      staged_sub_q, staged_sub_d;
    packet_header_t        active_hdr_q, active_hdr_d;
    subpacket_t [3:0]      active_sub_q, active_sub_d;
    logic [7:0]            ecc_h_q, ecc_h_d;
    logic [3:0][7:0]       ecc_s_q, ecc_s_d;
    logic                  enable_q, enable_d;
    logic [8:0]            data_q, data_d;
    logic                  done_q, done_d;

    logic                  hdr_bit;
    logic [3:0][1:0]       sub_bits;
    logic [7:0]            ecc_h_next;
    logic [3:0][7:0]       ecc_s_next;
    logic                  start_acc;
    logic                  load_acc;

    assign in_ready      = !staged_full_q;
    assign packet_enable = enable_q;
    assign packet_data   = data_q;
    assign packet_done   = done_q;

    assign start_acc = start && ((state_q == ST_IDLE) || (cnt_q == LAST_CNT));
    assign load_acc  = in_valid && !staged_full_q;

    // Pick the current data bits for each lane while still in the data phase
    always_comb begin
        hdr_bit  = 1'b0;
        sub_bits = '0;
        if (cnt_q < HDR_CNT) begin
            hdr_bit = active_hdr_q[cnt_q];
        end
        if (cnt_q < SUB_CNT) begin
            for (int unsigned i = 0; i < 4; i++) begin
                sub_bits[i] = {active_sub_q[i][{cnt_q, 1'b1}], active_sub_q[i][{cnt_q, 1'b0}]};
            end
        end
    end

    bch_ecc_step #(
        .BITS_PER_CLK(1),
        .ECC_POLY    (ECC_POLY)
    ) u_hdr_ecc (
        .ecc     (ecc_h_q),
        .data    (hdr_bit),
        .ecc_next(ecc_h_next)
    );

    for (genvar g = 0; g < 4; g++) begin : g_sub_ecc
        bch_ecc_step #(
            .BITS_PER_CLK(2),
            .ECC_POLY    (ECC_POLY)
        ) u_sub_ecc (
            .ecc     (ecc_s_q[g]),
            .data    (sub_bits[g]),
            .ecc_next(ecc_s_next[g])
        );
    end

    // Next-state: staging, slot sequencing, parity accumulation and output word
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        staged_full_d = staged_full_q;
        staged_hdr_d  = staged_hdr_q;
        staged_sub_d  = staged_sub_q;
        active_hdr_d  = active_hdr_q;
        active_sub_d  = active_sub_q;
        ecc_h_d       = ecc_h_q;
        ecc_s_d       = ecc_s_q;
        enable_d      = 1'b0;
        data_d        = '0;
        done_d        = 1'b0;

        if (state_q == ST_SEND) begin
            enable_d = 1'b1;
            done_d   = (cnt_q == LAST_CNT);
            cnt_d    = cnt_q + 5'd1;

            if (cnt_q < HDR_CNT) begin
                data_d[0] = hdr_bit;
                ecc_h_d   = ecc_h_next;
            end else begin
                data_d[0] = ecc_h_q[cnt_q[2:0]];
            end

            for (int unsigned i = 0; i < 4; i++) begin
                if (cnt_q < SUB_CNT) begin
                    data_d[1 + i] = sub_bits[i][0];
                    data_d[5 + i] = sub_bits[i][1];
                    ecc_s_d[i]    = ecc_s_next[i];
                end else begin
                    data_d[1 + i] = ecc_s_q[i][{cnt_q[1:0], 1'b0}];
                    data_d[5 + i] = ecc_s_q[i][{cnt_q[1:0], 1'b1}];
                end
            end

            if (cnt_q == LAST_CNT) begin
                state_d = ST_IDLE;
            end
        end

        // A start reads the staging registers as they were before this edge,
        // so a packet offered in the same cycle waits for the next slot.
        if (start_acc) begin
            state_d       = ST_SEND;
            cnt_d         = '0;
            ecc_h_d       = '0;
            ecc_s_d       = '0;
            active_hdr_d  = staged_full_q ? staged_hdr_q : '0;
            active_sub_d  = staged_full_q ? staged_sub_q : '0;
            staged_full_d = 1'b0;
        end

        if (load_acc) begin
            staged_hdr_d  = in_header;
            staged_sub_d  = in_sub;
            staged_full_d = 1'b1;
        end
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk_pixel) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            staged_full_q <= 1'b0;
            staged_hdr_q  <= '0;
            staged_sub_q  <= '0;
            active_hdr_q  <= '0;
            active_sub_q  <= '0;
            ecc_h_q       <= '0;
            ecc_s_q       <= '0;
            enable_q      <= 1'b0;
            data_q        <= '0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            staged_full_q <= staged_full_d;
            staged_hdr_q  <= staged_hdr_d;
            staged_sub_q  <= staged_sub_d;
            active_hdr_q  <= active_hdr_d;
            active_sub_q  <= active_sub_d;
            ecc_h_q       <= ecc_h_d;
            ecc_s_q       <= ecc_s_d;
            enable_q      <= enable_d;
            data_q        <= data_d;
            done_q        <= done_d;
        end
    end

endmodule

// File: tb/tb_data_island_packet_serializer.sv
// Randomized and directed bench for data_island_packet_serializer against a slot-queue model.
module tb_data_island_packet_serializer;

    logic             clk_pixel = 1'b0;
    logic             reset_n;
    logic [23:0]      in_header;
    logic [3:0][55:0] in_sub;
    logic             in_valid;
    logic             in_ready;
    logic             start;
    logic             packet_enable;
    logic [8:0]       packet_data;
    logic             packet_done;

    always #5 clk_pixel = ~clk_pixel;

    data_island_packet_serializer #(
        .ECC_POLY(8'h83)
    ) dut (
        .clk_pixel    (clk_pixel),
        .reset_n      (reset_n),
        .in_header    (in_header),
        .in_sub       (in_sub),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .start        (start),
        .packet_enable(packet_enable),
        .packet_data  (packet_data),
        .packet_done  (packet_done)
    );

    // Model: queue of {enable, done, data} words still to appear on the outputs
    logic [10:0]      exp_q[$];
    logic [10:0]      cur;
    logic             m_full;
    logic [23:0]      m_hdr;
    logic [3:0][55:0] m_sub;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // BCH parity over the first n bits of a stream, bit 0 first
    function automatic logic [7:0] bch(input logic [63:0] bits, input int n);
        logic [7:0] e;
        logic       fb;
        e = 8'h00;
        for (int k = 0; k < n; k++) begin
            fb = e[0] ^ bits[k];
            e  = e >> 1;
            if (fb) e = e ^ 8'h83;
        end
        return e;
    endfunction

    // Each lane stream is its data bits followed by parity; subpacket lanes carry two bits per clock
    task automatic push_slot(input logic [23:0] h, input logic [3:0][55:0] s);
        logic [31:0] lane0;
        logic [63:0] lane [4];
        logic [8:0]  w;
        lane0 = {bch({40'd0, h}, 24), h};
        for (int i = 0; i < 4; i++) lane[i] = {bch({8'd0, s[i]}, 56), s[i]};
        for (int c = 0; c < 32; c++) begin
            w[0] = lane0[c];
            for (int i = 0; i < 4; i++) begin
                w[1 + i] = lane[i][2 * c];
                w[5 + i] = lane[i][2 * c + 1];
            end
            exp_q.push_back({1'b1, (c == 31), w});
        end
    endtask

    task automatic model_edge();
        logic was_full;
        if (!reset_n) begin
            exp_q.delete();
            m_full = 1'b0;
            cur    = '0;
        end else begin
            was_full = m_full;
            cur = (exp_q.size() > 0) ? exp_q.pop_front() : 11'd0;
            // a new slot may begin only when at most the final word of the current one remains
            if (start && exp_q.size() == 0 && (cur == 11'd0 || cur[9])) begin
                if (was_full) push_slot(m_hdr, m_sub);
                else          push_slot('0, '0);
                m_full = 1'b0;
            end
            if (in_valid && !was_full) begin
                m_hdr  = in_header;
                m_sub  = in_sub;
                m_full = 1'b1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk_pixel);
        model_edge();
        #1;
        check("outputs", 32'({packet_enable, packet_done, packet_data}), 32'(cur));
        check("in_ready", 32'(in_ready), 32'(!m_full));
    endtask

    function automatic logic [55:0] rand56();
        return 56'({$urandom(), $urandom()});
    endfunction

    task automatic rand_pkt();
        in_header = 24'($urandom());
        for (int i = 0; i < 4; i++) in_sub[i] = rand56();
    endtask

    task automatic wait_size(input int sz);
        int k;
        k = 0;
        while (exp_q.size() != sz && k < 40) begin
            tick();
            k++;
        end
        check("wait_bound", 32'(exp_q.size()), 32'(sz));
    endtask

    logic [31:0] lane0_bits;
    logic [7:0]  other_or;
    int unsigned en_cnt;

    initial begin
        reset_n   = 1'b0;
        start     = 1'b0;
        in_valid  = 1'b0;
        in_header = '0;
        in_sub    = '0;
        m_full    = 1'b0;
        m_hdr     = '0;
        m_sub     = '0;
        cur       = '0;

        repeat (3) tick();
        reset_n = 1'b1;
        tick();

        // null packet from empty staging
        start = 1'b1; tick(); start = 1'b0;
        repeat (34) tick();

        // header 24'h000001 gives header parity 8'h4A
        in_header = 24'h000001; in_sub = '0; in_valid = 1'b1; tick(); in_valid = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        other_or = '0;
        for (int c = 0; c < 32; c++) begin
            tick();
            lane0_bits[c] = packet_data[0];
            other_or = other_or | packet_data[8:1];
        end
        check("ecc_lane0", lane0_bits, {8'h4A, 23'd0, 1'b1});
        check("ecc_other_lanes", 32'(other_or), 32'd0);
        tick();

        // subpacket 0 = 1
        in_header = '0; in_sub = '0; in_sub[0] = 56'h1; in_valid = 1'b1; tick(); in_valid = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        repeat (34) tick();

        // back-to-back, ignored start at c=10, blocked load while staging full
        rand_pkt(); in_valid = 1'b1; tick(); in_valid = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        repeat (4) tick();
        rand_pkt(); in_valid = 1'b1; tick();
        rand_pkt(); repeat (3) tick(); in_valid = 1'b0;
        wait_size(22);
        start = 1'b1; tick(); start = 1'b0;
        wait_size(1);
        start = 1'b1; tick(); start = 1'b0;
        check("b2b_done_edge", 32'(packet_done), 32'd1);
        en_cnt = 0;
        for (int c = 0; c < 32; c++) begin
            tick();
            if (packet_enable) en_cnt++;
        end
        check("b2b_second_slot_len", en_cnt, 32'd32);
        tick();
        check("b2b_idle_after", 32'(packet_enable), 32'd0);

        // reset in the middle of a slot
        rand_pkt(); in_valid = 1'b1; tick(); in_valid = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        rand_pkt(); in_valid = 1'b1; tick(); in_valid = 1'b0;
        wait_size(17);
        reset_n = 1'b0; tick(); reset_n = 1'b1;
        check("reset_mid_outputs", 32'({packet_enable, packet_done, packet_data, in_ready}), 32'd1);
        start = 1'b1; tick(); start = 1'b0;
        repeat (34) tick();

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            start    = ($urandom_range(0, 7) == 0);
            in_valid = ($urandom_range(0, 2) == 0);
            reset_n  = ($urandom_range(0, 399) != 0);
            rand_pkt();
            tick();
        end
        reset_n = 1'b1; start = 1'b0; in_valid = 1'b0;
        repeat (40) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
